// File: rtl/instr_ram_arbiter_pkg.sv
// rtl/instr_ram_arbiter_pkg.sv - shared types, constants and address check for the instruction RAM arbiter
package instr_ram_arb_pkg;

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } arb_state_e;

  localparam logic [31:0] NOP_INSTR_C = 32'h0000_0013;

  // Word range is always checked; alignment only matters for fetches.
  function automatic logic addr_bad(input logic [31:0] addr,
                                    input int unsigned depth_words,
                                    input logic check_align);
    logic misaligned;
    logic out_of_range;
    misaligned   = check_align & (addr[1:0] != 2'b00);
    out_of_range = ({2'b00, addr[31:2]} >= depth_words);
    return misaligned | out_of_range;
  endfunction

endpackage

// File: rtl/instr_ram_arbiter_if.sv
// rtl/instr_ram_arbiter_if.sv - loader, fetch and SRAM signal bundle for the instruction RAM arbiter
interface instr_ram_arbiter_if;

  logic        ld_valid;
  logic        ld_ready;
  logic [31:0] ld_addr;
  logic [31:0] ld_wdata;
  logic        ld_done;
  logic        if_req_valid;
  logic        if_req_ready;
  logic [31:0] if_req_addr;
  logic        if_rsp_valid;
  logic        if_rsp_ready;
  logic [31:0] if_rsp_instr;
  logic        if_rsp_err;
  logic        sram_en;
  logic        sram_we;
  logic [31:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;
  logic        boot_done;
  logic [15:0] ld_count;

  modport slave (
    input  ld_valid, ld_addr, ld_wdata, ld_done,
    input  if_req_valid, if_req_addr, if_rsp_ready, sram_rdata,
    output ld_ready, if_req_ready, if_rsp_valid, if_rsp_instr, if_rsp_err,
    output sram_en, sram_we, sram_addr, sram_wdata, boot_done, ld_count
  );

  modport master (
    output ld_valid, ld_addr, ld_wdata, ld_done,
    output if_req_valid, if_req_addr, if_rsp_ready, sram_rdata,
    input  ld_ready, if_req_ready, if_rsp_valid, if_rsp_instr, if_rsp_err,
    input  sram_en, sram_we, sram_addr, sram_wdata, boot_done, ld_count
  );

endinterface

// File: rtl/instr_ram_arbiter_rsp_buf.sv
// rtl/instr_ram_arbiter_rsp_buf.sv - one-deep fetch response buffer (pending read plus hold register)
module instr_rsp_buf #(
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        accept_i,
  input  logic        err_i,
  input  logic [31:0] sram_rdata_i,
  input  logic        rsp_ready_i,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_instr_o,
  output logic        rsp_err_o,
  output logic        rd_pend_o,
  output logic        hold_v_o
);

  logic        rd_pend_q, rd_pend_d;
  logic        rd_err_q, rd_err_d;
  logic        hold_v_q, hold_v_d;
  logic        hold_err_q, hold_err_d;
  logic [31:0] hold_instr_q, hold_instr_d;
  logic [31:0] live_instr;
  logic        capture;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_pend_q    <= 1'b0;
      rd_err_q     <= 1'b0;
      hold_v_q     <= 1'b0;
      hold_err_q   <= 1'b0;
      hold_instr_q <= '0;
    end else begin
      rd_pend_q    <= rd_pend_d;
      rd_err_q     <= rd_err_d;
      hold_v_q     <= hold_v_d;
      hold_err_q   <= hold_err_d;
      hold_instr_q <= hold_instr_d;
    end
  end

  // SRAM data is only valid for one cycle, so a stalled response is parked in the hold register.
  always_comb begin
    live_instr   = rd_err_q ? NOP_INSTR : sram_rdata_i;
    capture      = rd_pend_q & ~rsp_ready_i & ~hold_v_q;
    rd_pend_d    = accept_i;
    rd_err_d     = accept_i & err_i;
    hold_v_d     = capture | (hold_v_q & ~rsp_ready_i);
    hold_instr_d = capture ? live_instr : hold_instr_q;
    hold_err_d   = capture ? rd_err_q : hold_err_q;
  end

  always_comb begin
    rsp_valid_o = rd_pend_q | hold_v_q;
    rsp_instr_o = '0;
    rsp_err_o   = 1'b0;
    if (hold_v_q) begin
      rsp_instr_o = hold_instr_q;
      rsp_err_o   = hold_err_q;
    end else if (rd_pend_q) begin
      rsp_instr_o = live_instr;
      rsp_err_o   = rd_err_q;
    end
  end

  assign rd_pend_o = rd_pend_q;
  assign hold_v_o  = hold_v_q;

endmodule

// File: rtl/instr_ram_arbiter.sv
// rtl/instr_ram_arbiter.sv - BOOT/RUN sequencing and loader/fetch arbitration for the instruction SRAM port
module instr_ram_arbiter
  import instr_ram_arb_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS  = 16384,
  parameter int unsigned STARVE_LIMIT = 8,
  parameter bit          BOOT_LOAD    = 1'b1,
  parameter logic [31:0] NOP_INSTR    = NOP_INSTR_C
) (
  input logic                clk,
  input logic                resetn,
  instr_ram_arbiter_if.slave bus
);

  localparam int unsigned     CW          = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0]   STARVE_MAX  = CW'(STARVE_LIMIT);
  localparam arb_state_e      RESET_STATE = BOOT_LOAD ? BOOT : RUN;

  arb_state_e    state_q, state_d;
  logic [CW-1:0] starv_q, starv_d;
  logic [15:0]   ld_count_q, ld_count_d;

  logic        rd_pend, hold_v;
  logic        fetch_ok, fetch_win, ld_win;
  logic        if_err, ld_in_range;
  logic        rd_issue, wr_issue;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_instr;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= RESET_STATE;
      starv_q    <= '0;
      ld_count_q <= '0;
    end else begin
      state_q    <= state_d;
      starv_q    <= starv_d;
      ld_count_q <= ld_count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if ((state_q == BOOT) && bus.ld_done) begin
      state_d = RUN;
    end
  end

  // Fetch has priority in RUN unless the loader has already lost STARVE_LIMIT times in a row.
  always_comb begin
    if_err      = addr_bad(bus.if_req_addr, DEPTH_WORDS, 1'b1);
    ld_in_range = ~addr_bad(bus.ld_addr, DEPTH_WORDS, 1'b0);
    fetch_ok    = ~hold_v & (~rd_pend | bus.if_rsp_ready);
    fetch_win   = 1'b0;
    ld_win      = 1'b1;
    if (state_q == RUN) begin
      fetch_win = bus.if_req_valid & fetch_ok & (starv_q < STARVE_MAX);
      ld_win    = ~fetch_win & bus.ld_valid;
    end
    wr_issue = ld_win & bus.ld_valid & ld_in_range;
    rd_issue = fetch_win & ~if_err;
  end

  always_comb begin
    starv_d = '0;
    if ((state_q == RUN) && bus.ld_valid && !ld_win) begin
      starv_d = starv_q + 1'b1;
    end
    ld_count_d = ld_count_q;
    if (wr_issue && (ld_count_q != 16'hFFFF)) begin
      ld_count_d = ld_count_q + 16'd1;
    end
  end

  always_comb begin
    bus.sram_en    = wr_issue | rd_issue;
    bus.sram_we    = wr_issue;
    bus.sram_addr  = '0;
    bus.sram_wdata = '0;
    if (wr_issue) begin
      bus.sram_addr  = bus.ld_addr;
      bus.sram_wdata = bus.ld_wdata;
    end else if (rd_issue) begin
      bus.sram_addr  = bus.if_req_addr;
    end
  end

  instr_rsp_buf #(
    .NOP_INSTR (NOP_INSTR)
  ) u_rsp_buf (
    .clk          (clk),
    .resetn       (resetn),
    .accept_i     (fetch_win),
    .err_i        (if_err),
    .sram_rdata_i (bus.sram_rdata),
    .rsp_ready_i  (bus.if_rsp_ready),
    .rsp_valid_o  (rsp_valid),
    .rsp_instr_o  (rsp_instr),
    .rsp_err_o    (rsp_err),
    .rd_pend_o    (rd_pend),
    .hold_v_o     (hold_v)
  );

  assign bus.ld_ready     = ld_win;
  assign bus.if_req_ready = fetch_win;
  assign bus.if_rsp_valid = rsp_valid;
  assign bus.if_rsp_instr = rsp_instr;
  assign bus.if_rsp_err   = rsp_err;
  assign bus.boot_done    = (state_q == RUN);
  assign bus.ld_count     = ld_count_q;

endmodule

// File: tb/tb_instr_ram_arbiter.sv
// tb/tb_instr_ram_arbiter.sv - self-checking bench for instr_ram_arbiter
module tb_instr_ram_arbiter;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  instr_ram_arbiter_if b();
  instr_ram_arbiter_if b1();

  instr_ram_arbiter #(
    .DEPTH_WORDS(16384), .STARVE_LIMIT(8), .BOOT_LOAD(1'b1), .NOP_INSTR(32'h0000_0013)
  ) dut (.clk(clk), .resetn(resetn), .bus(b));

  instr_ram_arbiter #(
    .DEPTH_WORDS(16384), .STARVE_LIMIT(8), .BOOT_LOAD(1'b0), .NOP_INSTR(32'h0000_0013)
  ) dut_noboot (.clk(clk), .resetn(resetn), .bus(b1));

  assign b1.sram_rdata = 32'h0;

  logic [31:0] mem [0:16383];
  always @(posedge clk) begin
    if (b.sram_en) begin
      if (b.sram_we) begin
        if (b.sram_addr < 32'h0001_0000) mem[b.sram_addr[15:2]] <= b.sram_wdata;
      end else begin
        b.sram_rdata <= mem[b.sram_addr[15:2]];
      end
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic lv, input logic [31:0] la, input logic [31:0] lw, input logic done,
                       input logic fv, input logic [31:0] fa, input logic rr);
    b.ld_valid = lv; b.ld_addr = la; b.ld_wdata = lw; b.ld_done = done;
    b.if_req_valid = fv; b.if_req_addr = fa; b.if_rsp_ready = rr;
  endtask

  typedef struct {
    logic lv; logic [31:0] la; logic [31:0] lw; logic done; logic fv; logic [31:0] fa; logic rr;
    logic e_ldr; logic e_fr; logic e_en; logic e_we; logic e_rv; logic [31:0] e_ri; logic e_re; logic e_bd; logic [15:0] e_cnt;
  } vec_t;

  localparam int NV = 22;
  vec_t tbl [NV];

  typedef struct { logic [31:0] instr; logic err; } rsp_t;
  rsp_t        q[$];
  rsp_t        t;
  logic [31:0] ref_mem [0:63];
  int          front_age, wait_cnt;
  logic        phase_run, fok, exp_fr, popped, kept, ferr;
  logic [15:0] mcnt;
  logic        lv, fv, rr, done;
  logic [31:0] la, lw, fa;
  int          r;

  initial begin
    // lv la lw done fv fa rr | ld_ready req_ready en we rsp_valid instr err boot_done ld_count
    tbl[0]  = '{1'b1, 32'h0, 32'h11111111, 1'b0, 1'b1, 32'h0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 16'd0};
    tbl[1]  = '{1'b1, 32'h4, 32'h22222222, 1'b0, 1'b1, 32'h0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 16'd1};
    tbl[2]  = '{1'b1, 32'h8, 32'h33333333, 1'b0, 1'b1, 32'h0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 16'd2};
    tbl[3]  = '{1'b1, 32'hC, 32'h44444444, 1'b0, 1'b1, 32'h0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 16'd3};
    tbl[4]  = '{1'b0, 32'h0, 32'h0,        1'b1, 1'b1, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 16'd4};
    tbl[5]  = '{1'b0, 32'h0, 32'h0,        1'b0, 1'b1, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 16'd4};
    tbl[6]  = '{1'b0, 32'h0, 32'h0,        1'b0, 1'b1, 32'h4, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h11111111, 1'b0, 1'b1, 16'd4};
    tbl[7]  = '{1'b0, 32'h0, 32'h0,        1'b0, 1'b1, 32'h8, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h22222222, 1'b0, 1'b1, 16'd4};
    tbl[8]  = '{1'b0, 32'h0, 32'h0,        1'b0, 1'b1, 32'hC, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h33333333, 1'b0, 1'b1, 16'd4};
    tbl[9]  = '{1'b0, 32'h0, 32'h0,        1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h44444444, 1'b0, 1'b1, 16'd4};
    tbl[10] = '{1'b0, 32'h0, 32'h0,        1'b0, 1'b1, 32'h4, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 16'd4};
    tbl[11] = '{1'b1, 32'h8, 32'h55555555, 1'b0, 1'b1, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h22222222, 1'b0, 1'b1, 16'd4};
    tbl[12] = '{1'b0, 32'h0, 32'h0,        1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h22222222, 1'b0, 1'b1, 16'd5};
    tbl[13] = '{1'b0, 32'h0, 32'h0,        1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h22222222, 1'b0, 1'b1, 16'd5};
    tbl[14] = '{1'b0, 32'h0, 32'h0,        1'b0, 1'b1, 32'h8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h22222222, 1'b0, 1'b1, 16'd5};
    tbl[15] = '{1'b0, 32'h0, 32'h0,        1'b0, 1'b1, 32'h8, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 16'd5};
    tbl[16] = '{1'b0, 32'h0, 32'h0,        1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h55555555, 1'b0, 1'b1, 16'd5};
    tbl[17] = '{1'b0, 32'h0, 32'h0,        1'b0, 1'b1, 32'h2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 16'd5};
    tbl[18] = '{1'b0, 32'h0, 32'h0,        1'b0, 1'b1, 32'h10000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h13, 1'b1, 1'b1, 16'd5};
    tbl[19] = '{1'b1, 32'h10000, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h13, 1'b1, 1'b1, 16'd5};
    tbl[20] = '{1'b0, 32'h0, 32'h0,        1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 16'd5};
    tbl[21] = '{1'b0, 32'h0, 32'h0,        1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 16'd5};

    for (int i = 0; i < 16384; i++) mem[i] <= 32'h0;
    for (int i = 0; i < 64; i++) ref_mem[i] = 32'h0;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    b1.ld_valid = 1'b0; b1.ld_addr = 32'h0; b1.ld_wdata = 32'h0; b1.ld_done = 1'b0;
    b1.if_req_valid = 1'b1; b1.if_req_addr = 32'h0; b1.if_rsp_ready = 1'b1;

    resetn = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_rsp_valid", b.if_rsp_valid, 1'b0);
    chk("rst_rsp_instr", b.if_rsp_instr, 32'h0);
    chk("rst_ld_count", b.ld_count, 16'd0);
    chk("rst_boot_done", b.boot_done, 1'b0);
    chk("rst_req_ready", b.if_req_ready, 1'b0);
    chk("rst_sram_en", b.sram_en, 1'b0);
    chk("rst_noboot_boot_done", b1.boot_done, 1'b1);
    resetn = 1'b1;
    #1;
    chk("noboot_cycle1_req_ready", b1.if_req_ready, 1'b1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("noboot_first_rsp", b1.if_rsp_valid, 1'b1);
    @(posedge clk); #1;

    for (int i = 0; i < NV; i++) begin
      drive(tbl[i].lv, tbl[i].la, tbl[i].lw, tbl[i].done, tbl[i].fv, tbl[i].fa, tbl[i].rr);
      @(negedge clk);
      chk($sformatf("v%0d ld_ready", i), b.ld_ready, tbl[i].e_ldr);
      chk($sformatf("v%0d if_req_ready", i), b.if_req_ready, tbl[i].e_fr);
      chk($sformatf("v%0d sram_en", i), b.sram_en, tbl[i].e_en);
      chk($sformatf("v%0d sram_we", i), b.sram_we, tbl[i].e_we);
      chk($sformatf("v%0d rsp_valid", i), b.if_rsp_valid, tbl[i].e_rv);
      chk($sformatf("v%0d rsp_instr", i), b.if_rsp_instr, tbl[i].e_ri);
      chk($sformatf("v%0d rsp_err", i), b.if_rsp_err, tbl[i].e_re);
      chk($sformatf("v%0d boot_done", i), b.boot_done, tbl[i].e_bd);
      chk($sformatf("v%0d ld_count", i), b.ld_count, tbl[i].e_cnt);
      @(posedge clk); #1;
    end

    for (int k = 1; k <= 9; k++) begin
      drive(1'b1, 32'h10, 32'h66666666, 1'b0, 1'b1, 32'h0, 1'b1);
      @(negedge clk);
      chk($sformatf("starve%0d ld_ready", k), b.ld_ready, (k == 9));
      chk($sformatf("starve%0d if_req_ready", k), b.if_req_ready, (k != 9));
      @(posedge clk); #1;
    end
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h10, 1'b1);
    @(negedge clk);
    chk("starve_after_req_ready", b.if_req_ready, 1'b1);
    chk("starve_ld_count", b.ld_count, 16'd6);
    @(posedge clk); #1;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
    @(negedge clk);
    chk("starve_readback", b.if_rsp_instr, 32'h66666666);
    @(posedge clk); #1;

    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h0, 1'b1);
    @(negedge clk);
    chk("midrst_accept", b.if_req_ready, 1'b1);
    @(posedge clk); #1;
    resetn = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    #1;
    chk("midrst_rsp_valid", b.if_rsp_valid, 1'b0);
    chk("midrst_boot_done", b.boot_done, 1'b0);
    chk("midrst_ld_count", b.ld_count, 16'd0);
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk); #1;

    q.delete();
    front_age = 0; wait_cnt = 0; phase_run = 1'b0; mcnt = 16'd0;
    for (int i = 0; i < 600; i++) begin
      lv = ($urandom_range(0, 1) != 0);
      lw = $urandom;
      r  = $urandom_range(0, 9);
      la = (r == 0) ? (32'h10000 + ($urandom_range(0, 15) << 2)) : (32'd128 + ($urandom_range(0, 15) << 2));
      r  = $urandom_range(0, 9);
      fa = 32'd128 + ($urandom_range(0, 15) << 2);
      if (r == 0) fa = 32'h10000 + ($urandom_range(0, 15) << 2);
      else if (r == 1) fa = fa + $urandom_range(1, 3);
      fv = ($urandom_range(0, 3) != 0);
      rr = ($urandom_range(0, 3) != 0);
      done = (i == 30) || ((i > 30) && ($urandom_range(0, 31) == 0));
      drive(lv, la, lw, done, fv, fa, rr);
      @(negedge clk);

      fok    = (q.size() == 0) || ((front_age == 0) && rr);
      exp_fr = phase_run && fv && fok && (wait_cnt < 8);
      chk("rnd boot_done", b.boot_done, phase_run);
      chk("rnd ld_count", b.ld_count, mcnt);
      chk("rnd if_req_ready", b.if_req_ready, exp_fr);
      chk("rnd ld_ready", b.ld_ready, phase_run ? (lv & ~exp_fr) : 1'b1);
      chk("rnd rsp_valid", b.if_rsp_valid, (q.size() != 0));
      popped = 1'b0;
      if (q.size() != 0) begin
        chk("rnd rsp_instr", b.if_rsp_instr, q[0].instr);
        chk("rnd rsp_err", b.if_rsp_err, q[0].err);
        if (rr) begin
          void'(q.pop_front());
          popped = 1'b1;
        end
      end
      kept = (q.size() != 0) && !popped;
      if (b.if_req_ready) begin
        ferr = (fa[1:0] != 2'b00) || (fa >= 32'h10000);
        if (ferr) chk("rnd err_fetch_sram_en", b.sram_en, 1'b0);
        else chk("rnd rd_port", {b.sram_en, b.sram_we, b.sram_addr}, {1'b1, 1'b0, fa});
        t.err   = ferr;
        t.instr = ferr ? 32'h13 : ref_mem[fa[7:2]];
        q.push_back(t);
      end else if (b.ld_ready && lv) begin
        if (la < 32'h10000) begin
          chk("rnd wr_port", {b.sram_en, b.sram_we, b.sram_addr}, {1'b1, 1'b1, la});
          chk("rnd wr_data", b.sram_wdata, lw);
          ref_mem[la[7:2]] = lw;
          if (mcnt != 16'hFFFF) mcnt = mcnt + 16'd1;
        end else begin
          chk("rnd oor_wr_sram_en", b.sram_en, 1'b0);
        end
      end else begin
        chk("rnd sram_idle", b.sram_en, 1'b0);
      end
      front_age = kept ? front_age + 1 : 0;
      wait_cnt  = (phase_run && lv && !b.ld_ready) ? wait_cnt + 1 : 0;
      if (!phase_run && done) phase_run = 1'b1;
      @(posedge clk); #1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_ram_arbiter.md
Name: instr_ram_arbiter

Overview:
- Controller in front of the word-wide instruction SRAM (four byte-lane banks sharing one address, one enable, one write-enable, 1-cycle synchronous read).
- Shares the single SRAM port between two requesters:
  - the fetch unit (reads);
  - the program loader (word writes: boot image, debug patching).
- Sequences a BOOT phase (loader only), then a RUN phase (fetch priority with a starvation guard for the loader).
- Buffers one fetch response so fetch back-pressure never loses SRAM read data.

Parameters:
- DEPTH_WORDS, 16384, SRAM depth in 32-bit words; word address must be < DEPTH_WORDS.
- STARVE_LIMIT, 8, consecutive cycles a loader request may lose arbitration before it is forced through.
- BOOT_LOAD, 1, 1 = leave reset in BOOT; 0 = leave reset directly in RUN.
- NOP_INSTR, 32'h00000013, instruction returned with an error response.

Ports:
- clk  in  1  clock.
- resetn  in  1  asynchronous active-low reset.
- ld_valid  in  1  loader write request.
- ld_ready  out  1  loader write accepted this cycle.
- ld_addr  in  32  loader byte address; word = ld_addr[31:2].
- ld_wdata  in  32  loader write data.
- ld_done  in  1  pulse: image fully loaded.
- if_req_valid  in  1  fetch request.
- if_req_ready  out  1  fetch request accepted this cycle.
- if_req_addr  in  32  fetch byte address.
- if_rsp_valid  out  1  fetch response valid.
- if_rsp_ready  in  1  fetch unit consumes the response.
- if_rsp_instr  out  32  fetched instruction.
- if_rsp_err  out  1  misaligned or out-of-range fetch.
- sram_en  out  1  SRAM enable.
- sram_we  out  1  SRAM write enable.
- sram_addr  out  32  SRAM byte address (SRAM uses [31:2]).
- sram_wdata  out  32  SRAM write data.
- sram_rdata  in  32  SRAM read data; valid the cycle after a read.
- boot_done  out  1  high in RUN.
- ld_count  out  16  count of accepted in-range loader writes, saturating at 16'hFFFF.

Behaviour:

State machine:
- States BOOT and RUN. Reset enters BOOT if BOOT_LOAD=1, else RUN.
- BOOT -> RUN on the clock edge where ld_done=1. RUN has no exit except reset.
- ld_done is ignored in RUN.

Reset values:
- All outputs 0, except boot_done = ~BOOT_LOAD.
- Pending-read flag, hold register and starvation counter cleared.
- A response in flight at reset is discarded.

SRAM port:
- Combinational from the arbitration decision.
- Write grant: sram_en=1, sram_we=1, sram_addr=ld_addr, sram_wdata=ld_wdata.
- Read grant: sram_en=1, sram_we=0, sram_addr=if_req_addr.
- Otherwise: sram_en=0, sram_we=0.

BOOT phase:
- if_req_ready=0.
- ld_ready=1 every cycle; each ld_valid is one write.

RUN phase arbitration:
- fetch_ok = ~hold_v & (~rd_pend | if_rsp_ready).
- If if_req_valid & fetch_ok and starv_cnt < STARVE_LIMIT: fetch wins.
- Otherwise the loader wins if ld_valid.
- starv_cnt increments each cycle ld_valid is high and the loader loses; it clears when the loader is granted or ld_valid=0.
- At starv_cnt == STARVE_LIMIT the loader wins and if_req_ready=0 that cycle.
- if_req_ready=1 exactly when fetch wins.

Loader address handling:
- Out-of-range write (word >= DEPTH_WORDS) is accepted (ld_ready=1) but not issued; sram_en=0 and ld_count is not incremented.

Fetch response path (latency exactly 1 cycle from acceptance, independent of address):
- An accepted fetch sets rd_pend next cycle; rd_err_q records the error condition.
- Error condition: if_req_addr[1:0]!=0, or word address >= DEPTH_WORDS. An erroring fetch is accepted without an SRAM access.
- if_rsp_valid = rd_pend | hold_v.
- if_rsp_instr source:
  - hold_v: hold register;
  - rd_err_q: NOP_INSTR;
  - otherwise: sram_rdata.
- if_rsp_err follows the same source selection.
- rd_pend & ~if_rsp_ready & ~hold_v: capture the response into the hold register, set hold_v, clear rd_pend. This capture happens the same cycle any loader write is issued, so no data is lost.
- hold_v clears when if_rsp_ready=1.
- At most one response is outstanding; back-to-back fetches with if_rsp_ready held high give one response per cycle.

Simultaneous loader write and fetch read to the same word:
- Only one is granted per cycle, so no collision.
- A fetch after the write returns the new data.

Decomposition:
- Shared package instr_ram_arb_pkg holds:
  - the state enum {BOOT, RUN};
  - the NOP_INSTR constant;
  - an address-check function (alignment + range).
- One sub-module is natural: instr_rsp_buf (rd_pend / hold register / valid-ready logic).
- Arbitration and FSM stay in the top module.

Test Plan:
- Boot load: BOOT_LOAD=1, loader writes 0x11111111..0x44444444 to 0x0,0x4,0x8,0xC with if_req_valid=1 throughout -> if_req_ready=0, ld_count=4. Then ld_done -> boot_done=1 next cycle, and fetches of 0x0..0xC return the four words, 1-cycle latency, back-to-back.
- Back-pressure: fetch 0x4 with if_rsp_ready=0 for 3 cycles -> if_rsp_valid stays 1, instr stays 0x22222222, if_req_ready=0 until the response is consumed. A loader write to 0x8 during the stall does not corrupt the held data.
- Starvation: RUN, if_req_valid continuous, ld_valid held -> loader granted on cycle 9 (STARVE_LIMIT=8), if_req_ready=0 that cycle only.
- Errors: fetch 0x2 -> rsp_err=1, instr=0x00000013, sram_en=0. Fetch at word 16384 -> rsp_err=1. Loader write to word 16384 -> accepted, ld_count unchanged.
- Reset mid-read: fetch accepted, resetn low before the response -> if_rsp_valid=0, state=BOOT, ld_count=0.
- BOOT_LOAD=0: out of reset -> boot_done=1 and the first fetch is accepted on cycle 1.
